// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell is reused over DATA_WIDTH cycles to
// add two words plus carry-in, with valid/ready handshakes on both sides.
module serial_adder_seq #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  din_ci,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [DATA_WIDTH-1:0] dout_s,
  output logic                  dout_co,
  output logic                  dout_vld,
  input  logic                  dout_rd
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] sum_sh;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  carry;
  logic                  sum_bit;
  logic                  carry_next;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  last_bit;

  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  // Sum bits enter from the MSB side; the wide shift keeps this legal for width 1.
  assign sum_next   = DATA_WIDTH'({sum_bit, sum_sh} >> 1);
  assign accept     = din_vld & din_rd;
  assign last_bit   = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (dout_rd) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    din_rd   = (state == IDLE);
    dout_vld = (state == DONE);
  end

  // Result outputs load only on the final bit, so they stay frozen through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      dout_s  <= '0;
      dout_co <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= din_a;
            b_sh  <= din_b;
            carry <= din_ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= carry_next;
          sum_sh <= sum_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            dout_s  <= sum_next;
            dout_co <= carry_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: directed tests on a 4-bit build,
// exhaustive 1-bit build, and a randomized sweep on an 8-bit build.
module tb_serial_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst_n;

  logic [3:0] din_a4, din_b4, dout_s4;
  logic       din_ci4, din_vld4, din_rd4, dout_co4, dout_vld4, dout_rd4;

  logic [7:0] din_a8, din_b8, dout_s8;
  logic       din_ci8, din_vld8, din_rd8, dout_co8, dout_vld8, dout_rd8;

  logic [0:0] din_a1, din_b1, dout_s1;
  logic       din_ci1, din_vld1, din_rd1, dout_co1, dout_vld1, dout_rd1;

  serial_adder_seq #(.DATA_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .din_a(din_a4), .din_b(din_b4), .din_ci(din_ci4), .din_vld(din_vld4), .din_rd(din_rd4),
    .dout_s(dout_s4), .dout_co(dout_co4), .dout_vld(dout_vld4), .dout_rd(dout_rd4)
  );

  serial_adder_seq #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .din_a(din_a8), .din_b(din_b8), .din_ci(din_ci8), .din_vld(din_vld8), .din_rd(din_rd8),
    .dout_s(dout_s8), .dout_co(dout_co8), .dout_vld(dout_vld8), .dout_rd(dout_rd8)
  );

  serial_adder_seq #(.DATA_WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .din_a(din_a1), .din_b(din_b1), .din_ci(din_ci1), .din_vld(din_vld1), .din_rd(din_rd1),
    .dout_s(dout_s1), .dout_co(dout_co1), .dout_vld(dout_vld1), .dout_rd(dout_rd1)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int accept_cyc;
  int waited;
  int held;
  logic       seen;
  logic [7:0] ra, rb;
  logic       rci;
  logic [8:0] expect8;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge while the 4-bit block is idle.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic ci);
    din_a4     = a;
    din_b4     = b;
    din_ci4    = ci;
    din_vld4   = 1'b1;
    accept_cyc = cyc;
  endtask

  task automatic waitResult4();
    waited = 0;
    while (!dout_vld4 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic runOp4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic ci);
    logic [4:0] expected;
    expected = 5'(a) + 5'(b) + 5'(ci);
    checkOutput({tag, "_idle_rd"}, din_rd4, 1);
    applyStimulus(a, b, ci);
    @(negedge clk);
    din_vld4 = 1'b0;
    checkOutput({tag, "_rd_drop"}, din_rd4, 0);
    waitResult4();
    checkOutput({tag, "_latency"}, cyc - accept_cyc, 5);
    checkOutput({tag, "_sum"}, {dout_co4, dout_s4}, expected);
    @(negedge clk);
    checkOutput({tag, "_release"}, {dout_vld4, din_rd4}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    {din_a4, din_b4, din_ci4, din_vld4} = '0;
    dout_rd4 = 1'b1;
    {din_a8, din_b8, din_ci8, din_vld8, dout_rd8} = '0;
    {din_a1, din_b1, din_ci1, din_vld1} = '0;
    dout_rd1 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset4", {din_rd4, dout_vld4, dout_co4, dout_s4}, 7'h40);
    checkOutput("reset8", {din_rd8, dout_vld8, dout_co8, dout_s8}, 11'h400);
    checkOutput("reset1", {din_rd1, dout_vld1, dout_co1, dout_s1}, 4'h8);
    rst_n = 1'b1;
    @(negedge clk);

    runOp4("add_5_3", 4'h5, 4'h3, 1'b0);
    runOp4("add_f_1", 4'hF, 4'h1, 1'b0);
    runOp4("add_f_f_c", 4'hF, 4'hF, 1'b1);

    // Backpressure: result held while new operands are offered and ignored.
    dout_rd4 = 1'b0;
    checkOutput("bp_idle_rd", din_rd4, 1);
    applyStimulus(4'h7, 4'h7, 1'b0);
    @(negedge clk);
    din_a4 = 4'h3; din_b4 = 4'h4; din_ci4 = 1'b0; din_vld4 = 1'b1;
    checkOutput("bp_rd_drop", din_rd4, 0);
    waitResult4();
    checkOutput("bp_latency", cyc - accept_cyc, 5);
    checkOutput("bp_first", {dout_vld4, din_rd4, dout_co4, dout_s4}, 7'h4E);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold", {dout_vld4, din_rd4, dout_co4, dout_s4}, 7'h4E);
    end
    dout_rd4 = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {dout_vld4, din_rd4}, 2'b01);
    accept_cyc = cyc;
    @(negedge clk);
    din_vld4 = 1'b0;
    checkOutput("bp_new_rd_drop", din_rd4, 0);
    waitResult4();
    checkOutput("bp_new_latency", cyc - accept_cyc, 5);
    checkOutput("bp_new_sum", {dout_co4, dout_s4}, 5'h07);
    @(negedge clk);

    // Reset during the second RUN cycle discards the operation.
    checkOutput("rst_idle_rd", din_rd4, 1);
    applyStimulus(4'h9, 4'h9, 1'b0);
    @(negedge clk);
    din_vld4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid", {din_rd4, dout_vld4, dout_co4, dout_s4}, 7'h40);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dout_vld4) seen = 1'b1;
    end
    checkOutput("rst_no_emit", seen, 0);
    runOp4("after_rst", 4'h2, 4'h2, 1'b0);

    // Width 1: every operand combination, RUN lasts one cycle.
    for (int v = 0; v < 8; v++) begin
      checkOutput("w1_idle_rd", din_rd1, 1);
      din_a1 = v[0]; din_b1 = v[1]; din_ci1 = v[2]; din_vld1 = 1'b1;
      accept_cyc = cyc;
      @(negedge clk);
      din_vld1 = 1'b0;
      waited = 0;
      while (!dout_vld1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("w1_latency", cyc - accept_cyc, 2);
      checkOutput("w1_sum", {dout_co1, dout_s1}, 32'(v[0]) + 32'(v[1]) + 32'(v[2]));
      @(negedge clk);
    end

    // Width 8 random sweep with random stalls and ignored input traffic.
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom);
      expect8 = 9'(ra) + 9'(rb) + 9'(rci);
      checkOutput("sw_idle_rd", din_rd8, 1);
      din_a8 = ra; din_b8 = rb; din_ci8 = rci; din_vld8 = 1'b1;
      dout_rd8 = 1'($urandom);
      accept_cyc = cyc;
      @(negedge clk);
      waited = 0;
      while (!dout_vld8 && waited < 40) begin
        din_vld8 = 1'($urandom);
        din_a8   = 8'($urandom);
        din_b8   = 8'($urandom);
        din_ci8  = 1'($urandom);
        dout_rd8 = 1'($urandom);
        @(negedge clk);
        waited++;
      end
      checkOutput("sw_latency", cyc - accept_cyc, 9);
      held = 0;
      while (dout_vld8 && held < 40) begin
        checkOutput("sw_sum", {dout_co8, dout_s8}, expect8);
        din_vld8 = 1'($urandom);
        din_a8   = 8'($urandom);
        din_b8   = 8'($urandom);
        dout_rd8 = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        held++;
      end
      checkOutput("sw_release", dout_vld8, 0);
    end
    din_vld8 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder controller: time-multiplexes a single full-adder cell over all bit positions of a DATA_WIDTH-bit word.
- Trades latency for area; functionally equivalent to a DATA_WIDTH-bit ripple-carry adder.
- Accepts operands through a valid/ready input channel and returns sum plus carry-out through a valid/ready output channel.
- Sits between an operand producer and result consumer wherever a full parallel adder is too large.

Parameters:
- DATA_WIDTH, 4, operand and sum width in bits; legal range >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- din_a  in  DATA_WIDTH  operand A
- din_b  in  DATA_WIDTH  operand B
- din_ci  in  1  carry-in
- din_vld  in  1  input operands valid
- din_rd  out  1  block ready to accept operands
- dout_s  out  DATA_WIDTH  sum
- dout_co  out  1  carry-out
- dout_vld  out  1  result valid
- dout_rd  in  1  consumer ready for result

Behaviour:
- Reset (rst_n=0 sampled at edge):
  - state=IDLE; din_rd=1; dout_vld=0; dout_s=0; dout_co=0.
  - Operand, carry and counter registers cleared.
  - Reset has priority over every other event and aborts any RUN or DONE state; the in-flight result is discarded, never emitted.
- State machine, 3 states:
  - IDLE:
    - din_rd=1; dout_vld=0.
    - On din_vld&din_rd: capture din_a, din_b into shift registers; carry reg=din_ci; bit counter=0; go to RUN.
  - RUN:
    - din_rd=0; dout_vld=0.
    - Each cycle, the full-adder cell sees the LSB of the A shift reg, the LSB of the B shift reg, and the carry reg.
    - Sum bit = a^b^c; carry = a&b | a&c | b&c.
    - At the edge: sum bit shifts into the result reg from the MSB side (after DATA_WIDTH shifts, bit i sits at position i); A and B shift right by 1; carry reg=new carry; counter+1.
    - When counter==DATA_WIDTH-1 at the edge: go to DONE, with dout_s=final result and dout_co=final carry.
  - DONE:
    - din_rd=0; dout_vld=1; dout_s and dout_co held stable.
    - On dout_vld&dout_rd: go to IDLE; dout_vld=0 next cycle.
- Latency:
  - Accept edge at cycle T.
  - RUN occupies cycles T+1..T+DATA_WIDTH.
  - dout_vld=1 from cycle T+DATA_WIDTH+1.
- Throughput:
  - Maximum one operation per DATA_WIDTH+2 cycles.
  - No overlap: din_rd is asserted only in IDLE.
- Width rules:
  - Sum is modulo 2^DATA_WIDTH.
  - dout_co is carry out of bit DATA_WIDTH-1.
  - {dout_co, dout_s} == din_a + din_b + din_ci exactly.
  - Counter width: clog2(DATA_WIDTH), minimum 1 bit.
- Boundary conditions:
  - DATA_WIDTH=1: RUN lasts exactly 1 cycle.
  - din_vld may rise or drop at any time while din_rd=0; it is ignored and inputs are not sampled.
  - dout_rd while dout_vld=0 is ignored.
  - dout_rd held low indefinitely: DONE persists, outputs frozen.
  - dout_s/dout_co are registered outputs, never combinationally dependent on din_*.

Test Plan:
- Reset, then din_a=0x5, din_b=0x3, din_ci=0, din_vld=1 one cycle, dout_rd=1:
  - din_rd drops the cycle after accept.
  - dout_vld rises exactly 5 cycles after accept with dout_s=0x8, dout_co=0.
  - dout_vld drops next cycle; din_rd returns to 1.
- din_a=0xF, din_b=0x1, din_ci=0 -> dout_s=0x0, dout_co=1.
- din_a=0xF, din_b=0xF, din_ci=1 -> dout_s=0xF, dout_co=1.
- Backpressure:
  - Accept 0x7+0x7, ci=0, with dout_rd=0 for 10 cycles after dout_vld.
  - dout_s=0xE, dout_co=0 stay stable; din_rd=0 throughout despite din_vld=1 with new operands.
  - Those operands are not captured until dout_rd=1 and the block returns to IDLE.
- Reset mid-operation:
  - Assert rst_n=0 during the 2nd RUN cycle of 0x9+0x9.
  - Next cycle: din_rd=1, dout_vld=0, dout_s=0, dout_co=0; no result is ever emitted for that operation.
  - A following 0x2+0x2 yields 0x4, co=0.
- DATA_WIDTH=8 build, random sweep of 1000 operand triples with random dout_rd stalls:
  - Every result satisfies {dout_co, dout_s} == a+b+ci.
  - dout_vld occurs exactly 9 cycles after each accept.
